program_loader: RTL and testbench

- Writer side of the instruction stream that the control unit decodes.
- Accepts decoded instruction fields (tipo, op, Inm, registers, operand) from a host or test source over a valid/ready handshake.
- Packs each set of fields into a 32-bit instruction word and writes the words sequentially into instruction memory.
- Holds the processor in stall until the program is fully loaded; sits between the host/UART front end and the instruction-memory write port.

---
 rtl/isa_pkg.sv | 29 ++
 rtl/instr_encoder.sv | 29 ++
 rtl/program_loader.sv | 102 ++++++++++
 tb/tb_program_loader.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared instruction-word layout and loader state encoding.
// The field positions here must stay the exact inverse of the control path's field extraction.
package isa_pkg;

    localparam int INSTR_W = 32;

    localparam int TIPO_MSB = 31;
    localparam int TIPO_LSB = 30;
    localparam int OP_MSB   = 29;
    localparam int OP_LSB   = 28;
    localparam int INM_BIT  = 27;
    localparam int RD_MSB   = 26;
    localparam int RD_LSB   = 23;
    localparam int RN_MSB   = 22;
    localparam int RN_LSB   = 19;
    localparam int OPND_MSB = 18;
    localparam int OPND_LSB = 0;
    localparam int RM_MSB   = 18;
    localparam int RM_LSB   = 15;

    localparam int OPND_W = OPND_MSB - OPND_LSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } loader_state_t;

endpackage

// File: rtl/instr_encoder.sv
// Packs decoded instruction fields into one instruction word.
// Register-form instructions (inm=0) carry only Rm, so the low operand bits are zero-filled.
module instr_encoder
    import isa_pkg::*;
(
    input  logic [1:0]         tipo,
    input  logic [1:0]         op,
    input  logic               inm,
    input  logic [3:0]         rd,
    input  logic [3:0]         rn,
    input  logic [OPND_W-1:0]  operand,
    output logic [INSTR_W-1:0] word
);

    assign word[TIPO_MSB:TIPO_LSB] = tipo;
    assign word[OP_MSB:OP_LSB]     = op;
    assign word[INM_BIT]           = inm;
    assign word[RD_MSB:RD_LSB]     = rd;
    assign word[RN_MSB:RN_LSB]     = rn;
    assign word[RM_MSB:RM_LSB]     = operand[RM_MSB-OPND_LSB:RM_LSB-OPND_LSB];

    // Bits below Rm are only meaningful as immediate bits.
    generate
        for (genvar gi = OPND_LSB; gi < RM_LSB; gi++) begin : g_imm_low
            assign word[gi] = inm & operand[gi-OPND_LSB];
        end
    endgenerate

endmodule

// File: rtl/program_loader.sv
// Writes host-supplied instruction field sets as packed words into instruction memory,
// holding the processor in stall until the program has been fully loaded.
module program_loader
    import isa_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_tipo,
    input  logic [1:0]        in_op,
    input  logic              in_inm,
    input  logic [3:0]        in_rd,
    input  logic [3:0]        in_rn,
    input  logic [18:0]       in_operand,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_stall,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

    loader_state_t      state;
    logic [ADDR_W-1:0]  wr_ptr;
    logic [INSTR_W-1:0] packed_word;
    logic               transfer;
    logic [ADDR_W-1:0]  base_ptr;
    logic [ADDR_W:0]    base_count;
    logic               at_end;

    instr_encoder u_encoder (
        .tipo    (in_tipo),
        .op      (in_op),
        .inm     (in_inm),
        .rd      (in_rd),
        .rn      (in_rn),
        .operand (in_operand),
        .word    (packed_word)
    );

    // in_ready is high exactly while in LOAD, so it doubles as the accept qualifier.
    assign transfer = in_ready && in_valid;

    // A start seen together with a transfer makes that field set the first word of the new load.
    assign base_ptr   = start ? '0 : wr_ptr;
    assign base_count = start ? '0 : count;
    assign at_end     = (base_ptr == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_stall  <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            count      <= '0;
            wr_ptr     <= '0;
        end else begin
            imem_we <= 1'b0;

            if (start) begin
                state     <= LOAD;
                in_ready  <= 1'b1;
                cpu_stall <= 1'b1;
                done      <= 1'b0;
                overflow  <= 1'b0;
                count     <= '0;
                wr_ptr    <= '0;
            end

            if (transfer) begin
                imem_we    <= 1'b1;
                imem_addr  <= base_ptr;
                imem_wdata <= DATA_W'(packed_word);
                count      <= base_count + 1'b1;
                // The pointer stays on the last address when memory fills; it never wraps.
                if (in_last || at_end) begin
                    state     <= DONE;
                    in_ready  <= 1'b0;
                    cpu_stall <= 1'b0;
                    done      <= 1'b1;
                    overflow  <= !in_last;
                end else begin
                    wr_ptr <= base_ptr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomised and directed bench for program_loader: a large (ADDR_W=9) and a tiny (ADDR_W=2)
// loader share one stimulus stream and are each compared every cycle against a behavioural model.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, in_inm, in_last;
    logic [1:0]  in_tipo, in_op;
    logic [3:0]  in_rd, in_rn;
    logic [18:0] in_operand;

    logic        b_ready, b_we, b_stall, b_done, b_ovf;
    logic [8:0]  b_addr;
    logic [31:0] b_wdata;
    logic [9:0]  b_count;

    logic        s_ready, s_we, s_stall, s_done, s_ovf;
    logic [1:0]  s_addr;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    program_loader #(.ADDR_W(9), .DATA_W(32)) u_big (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(b_ready),
        .in_tipo(in_tipo), .in_op(in_op), .in_inm(in_inm), .in_rd(in_rd), .in_rn(in_rn),
        .in_operand(in_operand), .in_last(in_last), .imem_we(b_we), .imem_addr(b_addr),
        .imem_wdata(b_wdata), .cpu_stall(b_stall), .done(b_done), .overflow(b_ovf),
        .count(b_count)
    );

    program_loader #(.ADDR_W(2), .DATA_W(32)) u_small (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(s_ready),
        .in_tipo(in_tipo), .in_op(in_op), .in_inm(in_inm), .in_rd(in_rd), .in_rn(in_rn),
        .in_operand(in_operand), .in_last(in_last), .imem_we(s_we), .imem_addr(s_addr),
        .imem_wdata(s_wdata), .cpu_stall(s_stall), .done(s_done), .overflow(s_ovf),
        .count(s_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 = waiting for start, 1 = loading, 2 = program loaded.
    int          mode    [2];
    int unsigned m_count [2];
    bit          m_ovf   [2];
    bit          m_we    [2];
    int unsigned m_addr  [2];
    logic [31:0] m_word  [2];
    int unsigned cap     [2] = '{512, 4};

    function automatic logic [31:0] ref_word(input int unsigned tipo, op, inm, rd, rn, opnd);
        longint unsigned w, o;
        o = (inm != 0) ? opnd : (opnd / 32768) * 32768;
        w = tipo * (64'd1 << 30) + op * (64'd1 << 28) + inm * (64'd1 << 27)
          + rd * (64'd1 << 23) + rn * (64'd1 << 19) + o;
        return w[31:0];
    endfunction

    task automatic model_reset(input int i);
        mode[i]    = 0;
        m_count[i] = 0;
        m_ovf[i]   = 1'b0;
        m_we[i]    = 1'b0;
    endtask

    task automatic model_step(input int i);
        bit acc;
        if (rst) begin
            model_reset(i);
            return;
        end
        acc     = (mode[i] == 1) && in_valid;
        m_we[i] = 1'b0;
        if (start) begin
            mode[i]    = 1;
            m_count[i] = 0;
            m_ovf[i]   = 1'b0;
        end
        if (acc) begin
            m_we[i]   = 1'b1;
            m_addr[i] = m_count[i];
            m_word[i] = ref_word(in_tipo, in_op, in_inm, in_rd, in_rn, in_operand);
            m_count[i]++;
            if (in_last) begin
                mode[i] = 2;
            end else if (m_count[i] == cap[i]) begin
                mode[i]  = 2;
                m_ovf[i] = 1'b1;
            end
        end
    endtask

    task automatic check_inst(input int i, input string nm, input logic rdy, input logic we,
                              input logic stall, input logic dn, input logic ovf,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] cnt);
        check({nm, ".in_ready"},  rdy,   mode[i] == 1);
        check({nm, ".imem_we"},   we,    m_we[i]);
        check({nm, ".cpu_stall"}, stall, mode[i] != 2);
        check({nm, ".done"},      dn,    mode[i] == 2);
        check({nm, ".overflow"},  ovf,   m_ovf[i]);
        check({nm, ".count"},     cnt,   m_count[i]);
        if (m_we[i]) begin
            check({nm, ".imem_addr"},  addr,  m_addr[i]);
            check({nm, ".imem_wdata"}, wdata, m_word[i]);
        end
    endtask

    task automatic compare_all();
        check_inst(0, "big",   b_ready, b_we, b_stall, b_done, b_ovf, 32'(b_addr), b_wdata, 32'(b_count));
        check_inst(1, "small", s_ready, s_we, s_stall, s_done, s_ovf, 32'(s_addr), s_wdata, 32'(s_count));
    endtask

    // Inputs only change 1 time unit after a rising edge, so the model samples stable values.
    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
        $display("cyc t=%0t start=%0b valid=%0b last=%0b | big we=%0b a=%0d d=%08h cnt=%0d done=%0b | small we=%0b a=%0d cnt=%0d ovf=%0b",
                 $time, start, in_valid, in_last, b_we, b_addr, b_wdata, b_count, b_done,
                 s_we, s_addr, s_count, s_ovf);
    endtask

    task automatic drive(input bit v, input bit l, input int unsigned t, o, im, d, n, opnd);
        in_valid   = v;
        in_last    = l;
        in_tipo    = t[1:0];
        in_op      = o[1:0];
        in_inm     = im[0];
        in_rd      = d[3:0];
        in_rn      = n[3:0];
        in_operand = opnd[18:0];
    endtask

    task automatic drive_random(input bit v, input bit l);
        drive(v, l, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 19'h7FFFF));
    endtask

    task automatic pulse_start();
        in_valid = 1'b0;
        start    = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        rst   = 1'b0;
        start = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #1 rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        tick();
        rst = 1'b0;

        // Valid while idle must be ignored.
        drive(1, 0, 1, 1, 1, 1, 1, 5);
        repeat (3) tick();

        // Three back-to-back transfers, last on the third.
        pulse_start();
        drive(1, 0, 1, 2, 1, 3, 5, 'h123);
        tick();
        tick();
        in_last = 1'b1;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("dir3.count", 32'(b_count), 32'd3);
        tick();

        // Register form: operand low bits must be zero-filled.
        pulse_start();
        drive(1, 1, 2, 1, 0, 7, 9, 'h7FFFF);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("inm0.rm",  32'(b_wdata[18:15]), 32'hF);
        check("inm0.low", 32'(b_wdata[14:0]),  32'h0);

        // Five transfers without last: the small loader overflows after four.
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            drive_random(1, 0);
            tick();
        end
        check("ovf.small_ovf",   32'(s_ovf),   32'd1);
        check("ovf.small_ready", 32'(s_ready), 32'd0);
        drive_random(1, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();

        // Restart mid-load after two words.
        pulse_start();
        drive_random(1, 0);
        tick();
        tick();
        pulse_start();
        drive_random(1, 0);
        tick();
        in_valid = 1'b0;
        tick();
        check("restart.count", 32'(b_count), 32'd1);
        drive_random(1, 1);
        tick();
        in_valid = 1'b0;
        tick();

        // Reset in the middle of a back-to-back load.
        pulse_start();
        drive_random(1, 0);
        tick();
        tick();
        rst = 1'b1;
        #1;
        model_reset(0);
        model_reset(1);
        compare_all();
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();

        // Random programs with bubbles, occasional restarts and traffic after completion.
        for (int p = 0; p < 30; p++) begin
            int len;
            int k;
            len = $urandom_range(1, 12);
            k   = 0;
            pulse_start();
            while (k < len) begin
                if ($urandom_range(0, 3) != 0) begin
                    drive_random(1, k == len - 1);
                    k++;
                end else begin
                    drive_random(0, 0);
                    start = ($urandom_range(0, 29) == 0);
                end
                tick();
                start = 1'b0;
            end
            repeat ($urandom_range(1, 3)) begin
                drive_random($urandom_range(0, 1), $urandom_range(0, 1));
                tick();
            end
            in_valid = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
